// File: rtl/twiddle_mult_if.sv
// Sample stream into and out of the twiddle multiplier: input with frame marker, output with valid.
// The source side takes the master modport, the multiplier takes the slave modport.
interface twiddle_mult_if #(
  parameter int data_resolution = 16
);
  logic                              frame_sync;
  logic                              din_valid;
  logic signed [data_resolution-1:0] din_r;
  logic signed [data_resolution-1:0] din_i;
  logic                              dout_valid;
  logic signed [data_resolution-1:0] dout_r;
  logic signed [data_resolution-1:0] dout_i;

  modport master (
    output frame_sync, din_valid, din_r, din_i,
    input  dout_valid, dout_r, dout_i
  );

  modport slave (
    input  frame_sync, din_valid, din_r, din_i,
    output dout_valid, dout_r, dout_i
  );
endinterface

// File: rtl/twiddle_mult.sv
// Radix-2^2 inter-stage twiddle multiply, W_N^(m*q') per sample, 3 enabled cycles latency.
// No back-pressure: din_valid gaps pass through as dout_valid gaps; sys_en low freezes everything.
module twiddle_mult #(
  parameter int data_resolution    = 16,
  parameter int twiddle_resolution = 16,
  parameter int fft_len            = 16
) (
  input  logic          sys_clk,
  input  logic          sys_rst,
  input  logic          sys_en,
  twiddle_mult_if.slave bus
);
  localparam int DW        = data_resolution;
  localparam int TW        = twiddle_resolution;
  localparam int NW        = $clog2(fft_len);
  localparam int ROM_DEPTH = 3 * fft_len / 4;
  localparam int PW        = DW + TW;
  localparam int SW        = DW + TW + 1;
  localparam int SHIFT     = TW - 2;

  localparam logic signed [SW-1:0] RND   = SW'(1) << (SHIFT - 1);
  localparam logic signed [SW-1:0] MAX_W = {{(SW - DW + 1){1'b0}}, {(DW - 1){1'b1}}};
  localparam logic signed [SW-1:0] MIN_W = {{(SW - DW + 1){1'b1}}, {(DW - 1){1'b0}}};

  // Unit-magnitude twiddle scaled to 2^SHIFT, so W[0] = 1.0 is exactly representable.
  function automatic logic signed [TW-1:0] tw_val(input int e, input bit imag);
    real ang;
    real v;
    ang = 2.0 * 3.14159265358979323846 * e / fft_len;
    v   = imag ? -$sin(ang) : $cos(ang);
    return TW'($rtoi($floor(v * (2.0 ** SHIFT) + 0.5)));
  endfunction

  function automatic logic signed [DW-1:0] sat(input logic signed [SW-1:0] v);
    if (v > MAX_W)      return {1'b0, {(DW - 1){1'b1}}};
    else if (v < MIN_W) return {1'b1, {(DW - 1){1'b0}}};
    else                return v[DW-1:0];
  endfunction

  logic signed [TW-1:0] rom_c [ROM_DEPTH];
  logic signed [TW-1:0] rom_s [ROM_DEPTH];

  for (genvar g = 0; g < ROM_DEPTH; g++) begin : g_rom
    localparam logic signed [TW-1:0] C = tw_val(g, 1'b0);
    localparam logic signed [TW-1:0] S = tw_val(g, 1'b1);
    assign rom_c[g] = C;
    assign rom_s[g] = S;
  end

  logic [NW-1:0] n_cnt;
  logic [NW-1:0] n_cur;
  logic [1:0]    q;
  logic [1:0]    q_rev;
  logic [NW-3:0] m;
  logic [NW-1:0] e;

  // q' = {0,2,1,3}[q] is the bit reversal of q; fft_len is a power of 4 so n wraps naturally.
  assign n_cur = bus.frame_sync ? '0 : n_cnt;
  assign q     = n_cur[NW-1 -: 2];
  assign m     = n_cur[NW-3:0];
  assign q_rev = {q[0], q[1]};
  assign e     = NW'(m) * NW'(q_rev);

  logic                 s1_vld;
  logic signed [DW-1:0] s1_a;
  logic signed [DW-1:0] s1_b;
  logic signed [TW-1:0] s1_c;
  logic signed [TW-1:0] s1_d;
  logic                 s2_vld;
  logic signed [PW-1:0] p_ac;
  logic signed [PW-1:0] p_bd;
  logic signed [PW-1:0] p_ad;
  logic signed [PW-1:0] p_bc;
  logic signed [SW-1:0] sum_re;
  logic signed [SW-1:0] sum_im;

  assign sum_re = (SW'(p_ac) - SW'(p_bd) + RND) >>> SHIFT;
  assign sum_im = (SW'(p_ad) + SW'(p_bc) + RND) >>> SHIFT;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      n_cnt          <= '0;
      s1_vld         <= 1'b0;
      s1_a           <= '0;
      s1_b           <= '0;
      s1_c           <= '0;
      s1_d           <= '0;
      s2_vld         <= 1'b0;
      p_ac           <= '0;
      p_bd           <= '0;
      p_ad           <= '0;
      p_bc           <= '0;
      bus.dout_valid <= 1'b0;
      bus.dout_r     <= '0;
      bus.dout_i     <= '0;
    end else if (sys_en) begin
      s1_vld         <= bus.din_valid;
      s2_vld         <= s1_vld;
      bus.dout_valid <= s2_vld;
      if (bus.din_valid) begin
        n_cnt <= n_cur + NW'(1);
        s1_a  <= bus.din_r;
        s1_b  <= bus.din_i;
        s1_c  <= rom_c[e];
        s1_d  <= rom_s[e];
      end
      if (s1_vld) begin
        p_ac <= s1_a * s1_c;
        p_bd <= s1_b * s1_d;
        p_ad <= s1_a * s1_d;
        p_bc <= s1_b * s1_c;
      end
      // Outputs only move with a valid result so they hold across gaps.
      if (s2_vld) begin
        bus.dout_r <= sat(sum_re);
        bus.dout_i <= sat(sum_im);
      end
    end
  end
endmodule

// File: doc/twiddle_mult.md
TWIDDLE_MULT -- requirements
Module: twiddle_mult

Interface
REQ-001 Parameter data_resolution, default 16: width of each data component, signed two's complement.
REQ-002 Parameter twiddle_resolution, default 16: width of each twiddle component, signed two's complement.
REQ-003 Parameter fft_len, default 16: stage length N; power of 4, minimum 16.
REQ-004 sys_clk  in  1  single clock; all state updates on its rising edge.
REQ-005 sys_rst  in  1  asynchronous, active-high reset.
REQ-006 sys_en  in  1  global clock enable; when low, all registers hold.
REQ-007 frame_sync  in  1  qualified by din_valid; marks the sample as index n=0 of a frame.
REQ-008 din_valid  in  1  din_r/din_i carry a sample this cycle.
REQ-009 din_r, din_i  in  data_resolution each  complex input from the preceding butterfly-II output.
REQ-010 dout_valid  out  1  dout_r/dout_i carry a result this cycle.
REQ-011 dout_r, dout_i  out  data_resolution each  twiddle-multiplied complex output.

Function
REQ-012 Sample counter n, range 0..N-1, SHALL advance only on cycles with sys_en=1 and din_valid=1, and SHALL wrap from N-1 to 0.
REQ-013 A valid sample with frame_sync=1 SHALL be processed as n=0, and the counter SHALL become 1 after it.
REQ-014 Exponent derivation: q = n / (N/4), m = n mod (N/4), q' = {0,2,1,3}[q], e = m*q'.
REQ-015 Twiddle values: W[e] = cos(2*pi*e/N) - j*sin(2*pi*e/N), scaled by 2^(twiddle_resolution-2) and rounded to nearest.
REQ-016 The twiddle table SHALL be a ROM of 3N/4 entries, filled at elaboration; no runtime writes.
REQ-017 Products: re = a*c - b*d and im = a*d + b*c, where (a,b) is the input and (c,d) is the twiddle, at full precision of data_resolution+twiddle_resolution+1 bits.
REQ-018 Rounding: add 2^(twiddle_resolution-3), then arithmetic right shift by twiddle_resolution-2 (round half toward +inf).
REQ-019 Results outside the data_resolution signed range SHALL saturate to max positive or min negative; no wrap.
REQ-020 For e=0 the output SHALL equal the input exactly.
REQ-021 Latency SHALL be exactly 3 enabled cycles, din_valid to dout_valid.
REQ-022 Pipeline stages: S1 registers the input and the ROM twiddle; S2 registers the four products; S3 registers the sum/difference after round and saturate.
REQ-023 The valid flag SHALL travel through a 3-deep shift register advanced only when sys_en=1.
REQ-024 Gaps in din_valid SHALL produce matching gaps in dout_valid; there is no back-pressure.
REQ-025 When dout_valid=0, dout_r and dout_i SHALL hold their previous values.
REQ-026 While sys_en=0, the counter, pipeline and outputs SHALL all hold unchanged.

Reset
REQ-027 sys_rst=1 SHALL immediately clear the counter, all pipeline registers, dout_valid, dout_r and dout_i to 0, without waiting for a clock edge.
REQ-028 Samples in flight when reset asserts mid-frame SHALL be discarded.
REQ-029 The first valid sample after reset release SHALL be treated as n=0.

Verification (N=16, both resolutions 16)
REQ-030 Identity: 16 samples (1000,-2000) with frame_sync on the first -> outputs at n=0..4, 8 and 12 equal (1000,-2000); first dout_valid 3 cycles after the first din_valid.
REQ-031 Twiddle check: (16384,0) at n=5 (e=2) -> (11585,-11585); same input at n=13 (e=3) -> (6270,-15137).
REQ-032 Saturation: (-32768,-32768) at n=6 (e=4, twiddle -j) -> (-32768,32767).
REQ-033 Stall/gaps: toggle din_valid and sys_en randomly over 3 frames -> output sequence matches the golden model, and n advances only on enabled valid samples.
REQ-034 Reset mid-frame: assert sys_rst at n=7 with 2 samples in flight -> dout_valid=0 and outputs 0 immediately; no stale outputs appear afterwards; the next valid sample is handled as n=0.
REQ-035 frame_sync re-alignment: assert frame_sync at n=9 -> that sample uses e=0 and the next sample uses n=1.
